// File: rtl/data_mem_responder.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : data_mem_responder
// Brief    : 64-bit data memory with fixed-latency valid/ready request and
//            response handshake; optional DMEM_ERR_EN flags misaligned or
//            out-of-range requests.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT     = 2'd1;
    localparam logic [1:0] c_RESP     = 2'd2;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 2);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic            r_write;
    logic [c_AW-1:0] r_idx;
    logic [63:0]     r_wdata;
    logic [7:0]      r_wstrb;
    logic            r_err;
    logic [63:0]     r_rsp_rdata;
    logic            r_rsp_err;
    logic [63:0]     r_mem [0:DEPTH-1] = '{0: 64'd0, 1: 64'd1, 2: 64'd7, default: 64'd0};

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_req_err;
    logic            w_acc_write;
    logic            w_acc_err;
    logic [c_AW-1:0] w_acc_idx;
    logic [63:0]     w_acc_wdata;
    logic [7:0]      w_acc_wstrb;
    logic [63:0]     w_old;
    logic [63:0]     w_merged;

`ifdef DMEM_ERR_EN
    assign w_req_err = (req_addr[2:0] != 3'd0) || (|req_addr[63:c_AW+3]);
`else
    logic w_unused_addr;
    assign w_req_err     = 1'b0;
    assign w_unused_addr = ^{req_addr[63:c_AW+3], req_addr[2:0]};
`endif

    assign req_ready    = (r_state == c_IDLE);
    assign rsp_valid    = (r_state == c_RESP);
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign w_accept     = (r_state == c_IDLE) && req_valid;
    assign w_enter_resp = (w_state_nxt == c_RESP) && (r_state != c_RESP);

    // With LATENCY=1 the access happens on the acceptance edge, so the live
    // request fields are used instead of the latched copies.
    assign w_acc_write = (r_state == c_IDLE) ? req_write : r_write;
    assign w_acc_err   = (r_state == c_IDLE) ? w_req_err : r_err;
    assign w_acc_idx   = (r_state == c_IDLE) ? req_addr[c_AW+2:3] : r_idx;
    assign w_acc_wdata = (r_state == c_IDLE) ? req_wdata : r_wdata;
    assign w_acc_wstrb = (r_state == c_IDLE) ? req_wstrb : r_wstrb;
    assign w_old       = r_mem[w_acc_idx];

    for (genvar i = 0; i < 8; i++) begin : g_byte
        assign w_merged[8*i +: 8] = w_acc_wstrb[i] ? w_acc_wdata[8*i +: 8] : w_old[8*i +: 8];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = c_RESP;
                    end else begin
                        w_state_nxt = c_WAIT;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= 64'd0;
            r_wstrb     <= 8'd0;
            r_err       <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_idx   <= req_addr[c_AW+2:3];
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                r_err   <= w_req_err;
            end
            if (w_enter_resp) begin
                r_rsp_err   <= w_acc_err;
                r_rsp_rdata <= (w_acc_write || w_acc_err) ? 64'd0 : w_old;
            end
        end
    end

    // Memory contents survive reset; an edge seen while reset is held never writes.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && w_acc_write && !w_acc_err) begin
            r_mem[w_acc_idx] <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : tb_data_mem_responder
// Brief    : Directed self-checking bench for data_mem_responder
//            (LATENCY=2, DEPTH=256); DMEM_ERR_EN selects error expectations.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int n_chk  = 0;
    int n_fail = 0;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready=1, checking timing and data.
    task automatic do_req(input string tag, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wstrb,
                          input logic [63:0] exp_rdata, input logic exp_err);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_wstrb = wstrb;
        chk({tag, ".req_ready_idle"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".rsp_valid_wait"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".req_ready_wait"}, 64'(req_ready), 64'd0);
        @(negedge clk);
        chk({tag, ".rsp_valid_resp"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
        @(negedge clk);
        chk({tag, ".rsp_valid_idle"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".req_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0;
        req_wdata = 64'd0; req_wstrb = 8'd0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.req_ready", 64'(req_ready), 64'd1);
        chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset.rsp_rdata", rsp_rdata, 64'd0);
        chk("reset.rsp_err", 64'(rsp_err), 64'd0);
        rst_n = 1'b1;

        do_req("load_0x10", 1'b0, 64'h10, 64'd0, 8'h00, 64'd7, 1'b0);
`ifdef DMEM_ERR_EN
        do_req("load_0x0c_err", 1'b0, 64'h0C, 64'd0, 8'h00, 64'd0, 1'b1);
        do_req("load_0x808_err", 1'b0, 64'h808, 64'd0, 8'h00, 64'd0, 1'b1);
        do_req("store_err_nowrite", 1'b1, 64'h0C, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1);
        do_req("load_0x08_after_err", 1'b0, 64'h08, 64'd0, 8'h00, 64'd1, 1'b0);
`else
        do_req("load_0x808_wrap", 1'b0, 64'h808, 64'd0, 8'h00, 64'd1, 1'b0);
        do_req("load_0x0c_lowbits", 1'b0, 64'h0C, 64'd0, 8'h00, 64'd1, 1'b0);
`endif

        do_req("store_0x08", 1'b1, 64'h08, 64'h1122_3344_5566_7788, 8'h0F, 64'd0, 1'b0);
        do_req("load_0x08", 1'b0, 64'h08, 64'd0, 8'h00, 64'h0000_0000_5566_7788, 1'b0);

        do_req("store_0x10_nostrb", 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0);
        do_req("load_0x10_unchanged", 1'b0, 64'h10, 64'd0, 8'h00, 64'd7, 1'b0);

        // Response stall with a concurrent (ignored) store to the same word
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h00;
        @(negedge clk);
        req_write = 1'b1; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wstrb = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall.rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall.rsp_rdata", rsp_rdata, 64'd0);
            chk("stall.req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall.release_valid", 64'(rsp_valid), 64'd0);
        chk("stall.release_ready", 64'(req_ready), 64'd1);
        do_req("load_0x00_not_written", 1'b0, 64'h00, 64'd0, 8'h00, 64'd0, 1'b0);

        // Reset during WAIT aborts the store
        do_req("load_0x08_again", 1'b0, 64'h08, 64'd0, 8'h00, 64'h0000_0000_5566_7788, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h18;
        req_wdata = 64'h0000_0000_0000_DEAD; req_wstrb = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_wait.req_ready", 64'(req_ready), 64'd1);
        chk("rst_wait.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_wait.rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_wait.rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req("load_0x18_aborted", 1'b0, 64'h18, 64'd0, 8'h00, 64'd0, 1'b0);

        // Reset in RESP discards the response but keeps the store
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20;
        req_wdata = 64'h0000_0000_1234_ABCD; req_wstrb = 8'h03;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_resp.rsp_valid_before", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_resp.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_resp.req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        do_req("load_0x20_kept", 1'b0, 64'h20, 64'd0, 8'h00, 64'h0000_0000_0000_ABCD, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
